i2c_slave_responder: RTL and testbench

Byte-level I2C target (slave) that sits on the same SCL/SDA bus as the team's I2C master and answers its transactions. It detects START/STOP, matches a 7-bit address, and ACKs. On write transfers it presents each received byte to the fabric with a one-cycle strobe. On read transfers it shifts out a byte supplied by the fabric, MSB first. All bus activity is oversampled on the system clock; no logic runs on SCL.

---
 rtl/i2c_defs.sv | 34 +++
 rtl/i2c_bus_sync.sv | 35 +++
 rtl/i2c_slave_responder.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_defs.sv
// Shared I2C target definitions: state encodings, ACK/NACK bus levels and byte width.
package i2c_defs;

  localparam int BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_RX_BYTE  = 3'd3;
  localparam logic [2:0] ST_RX_ACK   = 3'd4;
  localparam logic [2:0] ST_TX_BYTE  = 3'd5;
  localparam logic [2:0] ST_TX_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    ADDR     = ST_ADDR,
    ADDR_ACK = ST_ADDR_ACK,
    RX_BYTE  = ST_RX_BYTE,
    RX_ACK   = ST_RX_ACK,
    TX_BYTE  = ST_TX_BYTE,
    TX_ACK   = ST_TX_ACK,
    IGNORE   = ST_IGNORE
  } state_t;

  // Busy covers every state in which this target owns part of the transfer.
  function automatic logic isBusyState(input state_t s);
    return !(s == IDLE || s == ADDR || s == IGNORE);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings one raw I2C line into the CLK domain: 2-FF synchronizer, then a detect stage
// that registers the level together with single-cycle rise/fall flags.
module i2c_bus_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, level_q, rise_q, fall_q;

  // Lines reset to the idle-high bus level so that leaving reset never fakes an edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= line_i;
      sync_q  <= meta_q;
      level_q <= sync_q;
      rise_q  <= sync_q & ~level_q;
      fall_q  <= ~sync_q & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// Byte-level I2C target: START/STOP detection, 7-bit address match, ACK, write and read transfers.
// Read support is compiled in only when I2C_SLAVE_READ_EN is defined; otherwise reads are NACKed.
module i2c_slave_responder
  import i2c_defs::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCL,
  input  logic       SDA_In,
  output logic       SDA_PullLow,
  input  logic [7:0] TxData,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       TxReq,
  output logic       Busy
);

`ifdef I2C_SLAVE_READ_EN
  localparam logic READ_OK = 1'b1;
`else
  localparam logic READ_OK = 1'b0;
`endif
  localparam logic [3:0] LAST_BIT = 4'(BYTE_W - 1);

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;
  logic startDet, stopDet;

  state_t            state_q, state_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d, shiftIn;
  logic              pull_q, pull_d;
  logic [BYTE_W-1:0] rxData_q, rxData_d;
  logic              rxValid_q, rxValid_d;
  logic              txReq_q, txReq_d;
  logic              unusedBits;

  i2c_bus_sync u_sclSync (
    .CLK     (CLK),
    .RESET   (RESET),
    .line_i  (SCL),
    .level_o (sclLevel),
    .rise_o  (sclRise),
    .fall_o  (sclFall)
  );

  i2c_bus_sync u_sdaSync (
    .CLK     (CLK),
    .RESET   (RESET),
    .line_i  (SDA_In),
    .level_o (sdaLevel),
    .rise_o  (sdaRise),
    .fall_o  (sdaFall)
  );

  assign startDet = sdaFall & sclLevel;
  assign stopDet  = sdaRise & sclLevel;
  assign shiftIn  = {shift_q[BYTE_W-2:0], sdaLevel};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      pull_q    <= 1'b0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      txReq_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      pull_q    <= pull_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
      txReq_q   <= txReq_d;
    end
  end

  // Bus conditions outrank SCL edges seen in the same cycle, and always let go of SDA.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    pull_d    = pull_q;
    rxData_d  = rxData_q;
    rxValid_d = 1'b0;
    txReq_d   = 1'b0;

    if (stopDet) begin
      state_d  = IDLE;
      bitCnt_d = '0;
      pull_d   = 1'b0;
    end else if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = '0;
      pull_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        ADDR: begin
          if (sclRise) begin
            shift_d  = shiftIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d = '0;
              if (shiftIn[BYTE_W-1:1] == SLAVE_ADDR && (READ_OK || !shiftIn[0])) begin
                state_d = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end

        // First fall after the 8th bit grabs SDA; the following fall ends the ACK slot.
        ADDR_ACK, RX_ACK: begin
          if (sclFall) begin
            if (!pull_q) begin
              pull_d = ~I2C_ACK;
            end else begin
              pull_d   = ~I2C_NACK;
              bitCnt_d = '0;
              state_d  = RX_BYTE;
`ifdef I2C_SLAVE_READ_EN
              if (state_q == ADDR_ACK && shift_q[0]) begin
                state_d = TX_BYTE;
                shift_d = TxData;
                pull_d  = ~TxData[BYTE_W-1];
                txReq_d = 1'b1;
              end
`endif
            end
          end
        end

        RX_BYTE: begin
          if (sclRise) begin
            shift_d  = shiftIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d  = '0;
              rxData_d  = shiftIn;
              rxValid_d = 1'b1;
              state_d   = RX_ACK;
            end
          end
        end

`ifdef I2C_SLAVE_READ_EN
        TX_BYTE: begin
          if (sclFall) begin
            if (bitCnt_q == LAST_BIT) begin
              pull_d   = ~I2C_NACK;
              bitCnt_d = '0;
              state_d  = TX_ACK;
            end else begin
              shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
              pull_d   = ~shift_q[BYTE_W-2];
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end
        end

        // A NACK ends the read at once; an ACK reloads on the fall that closes the slot.
        TX_ACK: begin
          if (sclRise && sdaLevel == I2C_NACK) begin
            state_d = IGNORE;
          end else if (sclFall) begin
            shift_d  = TxData;
            pull_d   = ~TxData[BYTE_W-1];
            txReq_d  = 1'b1;
            bitCnt_d = '0;
            state_d  = TX_BYTE;
          end
        end
`endif

        IGNORE: begin
        end

        default: begin
          state_d = IDLE;
          pull_d  = 1'b0;
        end
      endcase
    end
  end

`ifdef I2C_SLAVE_READ_EN
  assign unusedBits = shift_q[BYTE_W-1];
`else
  assign unusedBits = ^{TxData, shift_q[BYTE_W-1]};
`endif

  assign SDA_PullLow = pull_q;
  assign RxData      = rxData_q;
  assign RxValid     = rxValid_q;
  assign TxReq       = txReq_q;
  assign Busy        = isBusyState(state_q);

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged master drives a wired-AND bus.
// Read checks follow I2C_SLAVE_READ_EN, matching the RTL build.
module tb_i2c_slave_responder;

  localparam int Q = 5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SCL;
  logic       sdaMaster;
  logic       sdaBus;
  logic [7:0] TxData;
  logic       SDA_PullLow;
  logic [7:0] RxData;
  logic       RxValid;
  logic       TxReq;
  logic       Busy;

  int vectorCount = 0;
  int missCount   = 0;
  int rxCount     = 0;
  int txReqCount  = 0;
  int overlapCount = 0;
  int sclHighChange = 0;
  logic [7:0] rxLog[$];
  logic lastPull = 1'b0;
  logic pullSeen = 1'b0;
  logic busySeen = 1'b0;

  assign sdaBus = sdaMaster & ~SDA_PullLow;

  i2c_slave_responder #(.SLAVE_ADDR(7'h48)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .SCL         (SCL),
    .SDA_In      (sdaBus),
    .SDA_PullLow (SDA_PullLow),
    .TxData      (TxData),
    .RxData      (RxData),
    .RxValid     (RxValid),
    .TxReq       (TxReq),
    .Busy        (Busy)
  );

  always #5 CLK = ~CLK;

  // Watches strobes and the SDA driver just after every active edge.
  always @(posedge CLK) begin
    #1;
    if (RxValid) begin
      rxCount++;
      rxLog.push_back(RxData);
    end
    if (TxReq) txReqCount++;
    if (RxValid && TxReq) overlapCount++;
    if (SDA_PullLow) pullSeen = 1'b1;
    if (Busy) busySeen = 1'b1;
    if (!RESET && SCL && SDA_PullLow != lastPull) sclHighChange++;
    lastPull = SDA_PullLow;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic busStart();
    sdaMaster = 1'b0; waitClk(Q);
    SCL = 1'b0;       waitClk(Q);
  endtask

  task automatic busRestart();
    sdaMaster = 1'b1; waitClk(Q);
    SCL = 1'b1;       waitClk(Q);
    sdaMaster = 1'b0; waitClk(Q);
    SCL = 1'b0;       waitClk(Q);
  endtask

  task automatic busStop();
    sdaMaster = 1'b0; waitClk(Q);
    SCL = 1'b1;       waitClk(Q);
    sdaMaster = 1'b1; waitClk(Q);
  endtask

  task automatic applyStimulus(input logic b, output logic seen);
    sdaMaster = b; waitClk(Q);
    SCL = 1'b1;    waitClk(Q);
    seen = sdaBus; waitClk(Q);
    SCL = 1'b0;    waitClk(Q);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) applyStimulus(d[i], dummy);
    applyStimulus(1'b1, ack);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) applyStimulus(1'b1, d[i]);
    applyStimulus(masterAck, dummy);
  endtask

  initial begin
    logic       ack;
    logic       dummy;
    logic [7:0] data;
    int         rxBefore;
    int         txBefore;

    RESET = 1'b1; SCL = 1'b1; sdaMaster = 1'b1; TxData = 8'h00;
    waitClk(2);
    checkOutput("rst_pull",    16'(SDA_PullLow), 16'h0);
    checkOutput("rst_rxdata",  16'(RxData),      16'h00);
    checkOutput("rst_rxvalid", 16'(RxValid),     16'h0);
    checkOutput("rst_txreq",   16'(TxReq),       16'h0);
    checkOutput("rst_busy",    16'(Busy),        16'h0);
    RESET = 1'b0;
    waitClk(4);

    // Write 0xA5, 0x3C to 0x48
    rxBefore = rxCount;
    busStart();
    writeByte(8'h90, ack);
    checkOutput("wr_addr_ack", 16'(ack), 16'h0);
    checkOutput("wr_busy", 16'(Busy), 16'h1);
    writeByte(8'hA5, ack);
    checkOutput("wr_d0_ack", 16'(ack), 16'h0);
    writeByte(8'h3C, ack);
    checkOutput("wr_d1_ack", 16'(ack), 16'h0);
    checkOutput("wr_rx_count", 16'(rxCount - rxBefore), 16'h2);
    checkOutput("wr_rx0", 16'(rxLog[rxBefore]), 16'hA5);
    checkOutput("wr_rx1", 16'(rxLog[rxBefore + 1]), 16'h3C);
    sdaMaster = 1'b0; waitClk(Q);
    SCL = 1'b1;       waitClk(Q);
    sdaMaster = 1'b1; waitClk(3);
    checkOutput("stop_busy_3clk", 16'(Busy), 16'h1);
    waitClk(1);
    checkOutput("stop_busy_4clk", 16'(Busy), 16'h0);
    waitClk(Q);

    // Address miss: 0x49+W
    rxBefore = rxCount;
    pullSeen = 1'b0; busySeen = 1'b0;
    busStart();
    writeByte(8'h92, ack);
    checkOutput("miss_addr_nack", 16'(ack), 16'h1);
    writeByte(8'hFF, ack);
    checkOutput("miss_data_nack", 16'(ack), 16'h1);
    busStop();
    checkOutput("miss_pull_seen", 16'(pullSeen), 16'h0);
    checkOutput("miss_busy_seen", 16'(busySeen), 16'h0);
    checkOutput("miss_rx_count", 16'(rxCount - rxBefore), 16'h0);
    waitClk(Q);

`ifdef I2C_SLAVE_READ_EN
    txBefore = txReqCount;
    TxData = 8'h96;
    busStart();
    writeByte(8'h91, ack);
    checkOutput("rd_addr_ack", 16'(ack), 16'h0);
    checkOutput("rd_txreq_1", 16'(txReqCount - txBefore), 16'h1);
    TxData = 8'h01;
    readByte(1'b0, data);
    checkOutput("rd_byte0", 16'(data), 16'h96);
    checkOutput("rd_txreq_2", 16'(txReqCount - txBefore), 16'h2);
    readByte(1'b1, data);
    checkOutput("rd_byte1", 16'(data), 16'h01);
    checkOutput("rd_nack_pull", 16'(SDA_PullLow), 16'h0);
    checkOutput("rd_nack_busy", 16'(Busy), 16'h0);
    checkOutput("rd_txreq_end", 16'(txReqCount - txBefore), 16'h2);
    busStop();
`else
    txBefore = txReqCount;
    pullSeen = 1'b0; busySeen = 1'b0;
    TxData = 8'h96;
    busStart();
    writeByte(8'h91, ack);
    checkOutput("rdoff_addr_nack", 16'(ack), 16'h1);
    writeByte(8'h00, ack);
    checkOutput("rdoff_ignore_nack", 16'(ack), 16'h1);
    checkOutput("rdoff_txreq", 16'(txReqCount - txBefore), 16'h0);
    checkOutput("rdoff_pull_seen", 16'(pullSeen), 16'h0);
    checkOutput("rdoff_busy_seen", 16'(busySeen), 16'h0);
    busStop();
`endif
    waitClk(Q);

    // Repeated START after a partial byte, then reset while SDA is held low
    busStart();
    writeByte(8'h90, ack);
    checkOutput("rs_first_ack", 16'(ack), 16'h0);
    applyStimulus(1'b1, dummy);
    applyStimulus(1'b0, dummy);
    applyStimulus(1'b1, dummy);
    applyStimulus(1'b1, dummy);
    rxBefore = rxCount;
    busRestart();
`ifdef I2C_SLAVE_READ_EN
    TxData = 8'h00;
    writeByte(8'h91, ack);
    checkOutput("rs_read_ack", 16'(ack), 16'h0);
    checkOutput("rs_no_partial_rx", 16'(rxCount - rxBefore), 16'h0);
    checkOutput("rs_busy", 16'(Busy), 16'h1);
    checkOutput("rs_tx_bit7_pull", 16'(SDA_PullLow), 16'h1);
`else
    writeByte(8'h90, ack);
    checkOutput("rs_write_ack", 16'(ack), 16'h0);
    checkOutput("rs_no_partial_rx", 16'(rxCount - rxBefore), 16'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, dummy);
    checkOutput("rs_busy", 16'(Busy), 16'h1);
    checkOutput("rs_ack_pull", 16'(SDA_PullLow), 16'h1);
`endif
    RESET = 1'b1;
    waitClk(1);
    checkOutput("rs_reset_release", 16'(SDA_PullLow), 16'h0);
    checkOutput("rs_reset_busy", 16'(Busy), 16'h0);
    RESET = 1'b0;
    busStop();
    waitClk(Q);

    checkOutput("strobe_overlap", 16'(overlapCount), 16'h0);
    checkOutput("pull_change_scl_high", 16'(sclHighChange), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
